// File: rtl/evcap_pkg.sv
// Shared types and constants for the event capture sequencer.
// EVCAP_TIMESTAMP_EN selects the 5-word record with a 32-bit timestamp.
package evcap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        WRITE  = 2'd2,
        COMMIT = 2'd3
    } evcap_state_t;

    localparam logic [2:0] WORD_EVENT_INDEX = 3'd0;
    localparam logic [2:0] WORD_TOT_SHORT   = 3'd1;
    localparam logic [2:0] WORD_TOT_LONG    = 3'd2;
    localparam logic [2:0] WORD_TS_HI       = 3'd3;
    localparam logic [2:0] WORD_TS_LO       = 3'd4;

`ifdef EVCAP_TIMESTAMP_EN
    localparam int REC_WORDS = 5;
`else
    localparam int REC_WORDS = 3;
`endif

    localparam logic [2:0] LAST_WORD = 3'(REC_WORDS - 1);

endpackage

// File: rtl/event_capture_sequencer_if.sv
// Trigger/TOT inputs, control and word-wise readout bus of the event capture sequencer.
// The master side drives triggers and read requests; the slave side is the sequencer.
interface event_capture_sequencer_if #(
    parameter int DEPTH  = 256,
    parameter int DROP_W = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              TRIGGER_ACTIVE;
    logic [15:0]       TOT_SHORT;
    logic [15:0]       TOT_LONG;
    logic              SOFT_RESET;
    logic              RD_REQ;
    logic [15:0]       RD_DATA;
    logic              RD_VALID;
    logic              RD_EMPTY;
    logic [LW-1:0]     FILL_LEVEL;
    logic [DROP_W-1:0] DROP_COUNT;
    logic              BUSY;

    modport master (
        output TRIGGER_ACTIVE, TOT_SHORT, TOT_LONG, SOFT_RESET, RD_REQ,
        input  RD_DATA, RD_VALID, RD_EMPTY, FILL_LEVEL, DROP_COUNT, BUSY
    );

    modport slave (
        input  TRIGGER_ACTIVE, TOT_SHORT, TOT_LONG, SOFT_RESET, RD_REQ,
        output RD_DATA, RD_VALID, RD_EMPTY, FILL_LEVEL, DROP_COUNT, BUSY
    );
endinterface

// File: rtl/evcap_ram.sv
// Simple dual-port 16-bit x DEPTH RAM with one-cycle registered read.
// Contents are never reset so it maps onto embedded block RAM.
module evcap_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;
endmodule

// File: rtl/event_capture_sequencer.sv
// Captures TOT_SHORT/TOT_LONG into fixed-length records on each trigger rising edge and
// exposes only fully committed records for word readout. EVCAP_TIMESTAMP_EN adds a timestamp.
module event_capture_sequencer
    import evcap_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int CAPTURE_DELAY = 4,
    parameter int DROP_W        = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    event_capture_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ACCEPT_MAX = PW'(DEPTH - REC_WORDS);
    localparam logic [7:0]    DELAY_LAST = (CAPTURE_DELAY == 0) ? 8'd0 : 8'(CAPTURE_DELAY - 1);

    evcap_state_t      state_reg, state_next;
    logic              trig_q_reg;
    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]     wr_commit_reg, wr_commit_next;
    logic [PW-1:0]     rd_ptr_reg;
    logic [7:0]        delay_cnt_reg, delay_cnt_next;
    logic [2:0]        word_idx_reg, word_idx_next;
    logic [15:0]       event_index_reg, event_index_next;
    logic [DROP_W-1:0] drop_count_reg;
    logic              rd_valid_reg;
    logic [15:0]       tot_short_reg, tot_long_reg;

    logic          clear;
    logic          trig_edge;
    logic [PW-1:0] fill;
    logic          has_room;
    logic          rd_empty;
    logic          pop;
    logic          capture;
    logic          drop;
    logic          ram_we;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;

`ifdef EVCAP_TIMESTAMP_EN
    logic [31:0] ts_reg;
    logic [31:0] ts_latch_reg;
`endif

    assign clear     = !RESET || bus.SOFT_RESET;
    assign trig_edge = bus.TRIGGER_ACTIVE && !trig_q_reg;
    // Occupancy counts committed words only, so a partial record never reserves or exposes space.
    assign fill      = wr_commit_reg - rd_ptr_reg;
    assign has_room  = (fill <= ACCEPT_MAX);
    assign rd_empty  = (fill == '0);
    assign pop       = bus.RD_REQ && !rd_empty;
    assign drop      = trig_edge && ((state_reg != IDLE) || !has_room);

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        wr_commit_next   = wr_commit_reg;
        delay_cnt_next   = delay_cnt_reg;
        word_idx_next    = word_idx_reg;
        event_index_next = event_index_reg;
        capture          = 1'b0;
        ram_we           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (trig_edge && has_room) begin
                    delay_cnt_next = 8'd0;
                    word_idx_next  = 3'd0;
                    if (CAPTURE_DELAY == 0) begin
                        capture    = 1'b1;
                        state_next = WRITE;
                    end else begin
                        state_next = DELAY;
                    end
                end
            end
            DELAY: begin
                if (delay_cnt_reg == DELAY_LAST) begin
                    capture    = 1'b1;
                    state_next = WRITE;
                end else begin
                    delay_cnt_next = delay_cnt_reg + 8'd1;
                end
            end
            WRITE: begin
                ram_we        = 1'b1;
                wr_ptr_next   = wr_ptr_reg + PW'(1);
                word_idx_next = word_idx_reg + 3'd1;
                if (word_idx_reg == LAST_WORD) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                wr_commit_next   = wr_ptr_reg;
                event_index_next = event_index_reg + 16'd1;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_wdata = event_index_reg;
        case (word_idx_reg)
            WORD_TOT_SHORT: ram_wdata = tot_short_reg;
            WORD_TOT_LONG:  ram_wdata = tot_long_reg;
`ifdef EVCAP_TIMESTAMP_EN
            WORD_TS_HI:     ram_wdata = ts_latch_reg[31:16];
            WORD_TS_LO:     ram_wdata = ts_latch_reg[15:0];
`endif
            default:        ram_wdata = event_index_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            state_reg       <= IDLE;
            trig_q_reg      <= 1'b0;
            wr_ptr_reg      <= '0;
            wr_commit_reg   <= '0;
            rd_ptr_reg      <= '0;
            delay_cnt_reg   <= 8'd0;
            word_idx_reg    <= 3'd0;
            event_index_reg <= 16'd0;
            drop_count_reg  <= '0;
            rd_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            trig_q_reg      <= bus.TRIGGER_ACTIVE;
            wr_ptr_reg      <= wr_ptr_next;
            wr_commit_reg   <= wr_commit_next;
            delay_cnt_reg   <= delay_cnt_next;
            word_idx_reg    <= word_idx_next;
            event_index_reg <= event_index_next;
            rd_valid_reg    <= pop;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (drop && (drop_count_reg != {DROP_W{1'b1}})) begin
                drop_count_reg <= drop_count_reg + DROP_W'(1);
            end
        end
    end

    // Sampled TOT values need no reset: they are only read after a capture.
    always_ff @(posedge CLK) begin
        if (capture) begin
            tot_short_reg <= bus.TOT_SHORT;
            tot_long_reg  <= bus.TOT_LONG;
        end
    end

`ifdef EVCAP_TIMESTAMP_EN
    always_ff @(posedge CLK) begin
        if (clear) begin
            ts_reg <= 32'd0;
        end else begin
            ts_reg <= ts_reg + 32'd1;
        end
        if (capture) begin
            ts_latch_reg <= ts_reg;
        end
    end
`endif

    evcap_ram #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (ram_we && !clear),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (ram_wdata),
        .rd_en   (pop),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (ram_rdata)
    );

    assign bus.RD_DATA    = rd_valid_reg ? ram_rdata : 16'd0;
    assign bus.RD_VALID   = rd_valid_reg;
    assign bus.RD_EMPTY   = rd_empty;
    assign bus.FILL_LEVEL = fill;
    assign bus.DROP_COUNT = drop_count_reg;
    assign bus.BUSY       = (state_reg != IDLE);
endmodule

// File: tb/tb_event_capture_sequencer.sv
// Randomized bench for event_capture_sequencer with an event-level reference model and a
// read scoreboard. Define EVCAP_TIMESTAMP_EN to exercise the 5-word timestamped record.
module tb_event_capture_sequencer;
    localparam int DEPTH = 8;
    localparam int D     = 4;
`ifdef EVCAP_TIMESTAMP_EN
    localparam int R = 5;
`else
    localparam int R = 3;
`endif

    typedef struct {
        logic [15:0] word;
        int          cyc;
    } exp_t;

    logic CLK;
    logic RESET;
    int   cyc_cnt = 0;
    int   checks  = 0;
    int   errors  = 0;

    event_capture_sequencer_if #(.DEPTH(DEPTH), .DROP_W(16)) bus ();

    event_capture_sequencer #(
        .DEPTH         (DEPTH),
        .CAPTURE_DELAY (D),
        .DROP_W        (16)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    // Reference model: committed word FIFO plus countdowns for the busy window and TOT sampling.
    logic [15:0] m_fifo [$];
    exp_t        exp_q [$];
    int          m_busy_left = 0;
    int          m_cap_left  = 0;
    logic [15:0] m_drop      = 16'd0;
    logic [15:0] m_index     = 16'd0;
    logic [31:0] m_ts        = 32'd0;
    logic [31:0] m_ts_cap    = 32'd0;
    logic [15:0] m_short     = 16'd0;
    logic [15:0] m_long      = 16'd0;
    logic        m_prev_trig = 1'b0;
    bit          m_init      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic commit_record();
        m_fifo.push_back(m_index);
        m_fifo.push_back(m_short);
        m_fifo.push_back(m_long);
        if (R == 5) begin
            m_fifo.push_back(m_ts_cap[31:16]);
            m_fifo.push_back(m_ts_cap[15:0]);
        end
        m_index = m_index + 16'd1;
    endtask

    task automatic model_step(input logic rst_n, input logic srst, input logic trig,
                              input logic rdreq, input logic [15:0] s_in, input logic [15:0] l_in);
        logic edge_seen;
        logic was_busy;
        int   level;
        bit   cap;
        exp_t e;
        if (!rst_n || srst) begin
            m_fifo.delete();
            m_busy_left = 0;
            m_cap_left  = 0;
            m_drop      = 16'd0;
            m_index     = 16'd0;
            m_ts        = 32'd0;
            m_prev_trig = 1'b0;
            m_init      = 1'b1;
            return;
        end
        edge_seen = trig && !m_prev_trig;
        was_busy  = (m_busy_left != 0);
        level     = m_fifo.size();
        cap       = 1'b0;
        if (rdreq && level > 0) begin
            e.word = m_fifo.pop_front();
            e.cyc  = cyc_cnt + 1;
            exp_q.push_back(e);
        end
        if (m_cap_left > 0) begin
            m_cap_left--;
            if (m_cap_left == 0) cap = 1'b1;
        end
        if (was_busy) begin
            m_busy_left--;
            if (m_busy_left == 0) commit_record();
        end
        if (edge_seen) begin
            if (!was_busy && (DEPTH - level) >= R) begin
                m_busy_left = D + R + 1;
                if (D == 0) cap = 1'b1;
                else m_cap_left = D;
            end else if (m_drop != 16'hFFFF) begin
                m_drop = m_drop + 16'd1;
            end
        end
        if (cap) begin
            m_short  = s_in;
            m_long   = l_in;
            m_ts_cap = m_ts;
        end
        m_ts        = m_ts + 32'd1;
        m_prev_trig = trig;
    endtask

    // One clock: compare status against the model, then drive inputs for the next edge.
    task automatic cycle(input logic rst_n, input logic srst, input logic trig, input logic rdreq,
                         input logic [15:0] s_in, input logic [15:0] l_in);
        @(negedge CLK);
        if (m_init) begin
            chk("fill_level", 32'(bus.FILL_LEVEL), 32'(m_fifo.size()));
            chk("rd_empty", 32'(bus.RD_EMPTY), 32'(m_fifo.size() == 0));
            chk("busy", 32'(bus.BUSY), 32'(m_busy_left != 0));
            chk("drop_count", 32'(bus.DROP_COUNT), 32'(m_drop));
        end
        RESET              = rst_n;
        bus.SOFT_RESET     = srst;
        bus.TRIGGER_ACTIVE = trig;
        bus.RD_REQ         = rdreq;
        bus.TOT_SHORT      = s_in;
        bus.TOT_LONG       = l_in;
        model_step(rst_n, srst, trig, rdreq, s_in, l_in);
    endtask

    task automatic idle(input int n, input logic rdreq);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, rdreq, 16'($urandom), 16'($urandom));
    endtask

    // Read monitor: every RD_VALID must match the oldest expected pop, and no pop may go missing.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.RD_VALID === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].cyc > cyc_cnt) begin
                    errors++;
                    $display("FAIL rd_valid_unexpected: got RD_VALID=1 data 0x%04h, expected no valid (cycle %0d)",
                             bus.RD_DATA, cyc_cnt);
                end else begin
                    e = exp_q.pop_front();
                    checks--;
                    chk("rd_data", 32'(bus.RD_DATA), 32'(e.word));
                    $display("read word 0x%04h (expected 0x%04h) cycle %0d", bus.RD_DATA, e.word, cyc_cnt);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL rd_valid_missing: got RD_VALID=0, expected word 0x%04h (cycle %0d)", e.word, cyc_cnt);
            end
        end
    end

    initial begin
        int p_trig;
        int p_read;
        logic trig;
        RESET              = 1'b0;
        bus.SOFT_RESET     = 1'b0;
        bus.TRIGGER_ACTIVE = 1'b0;
        bus.RD_REQ         = 1'b0;
        bus.TOT_SHORT      = 16'd0;
        bus.TOT_LONG       = 16'd0;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        idle(1, 1'b0);
        chk("rd_data_reset", 32'(bus.RD_DATA), 32'h0);

        // Single trigger with known TOT values, then read the record back.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0345);
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0012, 16'h0345);
        idle(R, 1'b1);
        idle(3, 1'b0);

        // Fill to the boundary with no reads: the third record does not fit.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'(16'h100 + k), 16'(16'h200 + k));
            idle(D + R + 4, 1'b0);
        end
        idle(2 * R + 2, 1'b1);

        // Second edge while the first record is still in its delay window.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'hAAAA, 16'h5555);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'h5555);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'hBBBB, 16'h6666);
        idle(D + R + 4, 1'b0);
        idle(R + 2, 1'b1);

        // Soft reset while word 1 of a record is being written.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h2222);
        idle(D + 1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h3333, 16'h4444);
        idle(D + R + 4, 1'b0);
        idle(R + 2, 1'b1);

        // 100 records drained by a continuously asserted read request.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
            idle(D + R + 3, 1'b1);
        end

        // Random traffic with changing trigger and read intensity and occasional soft resets.
        trig = 1'b0;
        for (int blk = 0; blk < 8; blk++) begin
            p_trig = $urandom_range(5, 40);
            p_read = $urandom_range(0, 100);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 99) < p_trig) trig = ~trig;
                cycle(1'b1, ($urandom_range(0, 299) == 0), trig,
                      ($urandom_range(0, 99) < p_read), 16'($urandom), 16'($urandom));
            end
        end

        idle(D + R + 4, 1'b0);
        idle(DEPTH + 4, 1'b1);
        idle(3, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
